rom_burst_reader: RTL and testbench

- Bus master placed directly upstream of the byte-wide ROM memory system (window 0x400–0x4FF, active-low UDS/LDS lane strobes).
- On a start command, performs a burst of byte reads at stepped addresses. For each address it selects the correct lane strobe, holds the strobe for a programmed number of wait states, and captures the returned byte.
- Delivers each captured byte downstream on a valid/ready stream.
- Lane rule: address bit 6 = 0 → UDS; bit 6 = 1 → LDS.

---
 rtl/rom_burst_reader.sv | 209 ++++++++++++++++++++
 tb/tb_rom_burst_reader.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_burst_reader.sv
// -----------------------------------------------------------------------------
// rom_burst_reader
//
// Bus master that sits directly in front of the byte-wide ROM memory system
// (legal window MAP_LO..MAP_HI-1). A start command launches a burst of byte
// reads at addresses start_addr, start_addr+ADDR_STEP, ... For every byte the
// block drives the address, pulls the proper lane strobe low for
// WAIT_STATES+1 cycles, captures the returned byte on the final strobe edge
// and offers it downstream on a valid/ready stream.
//
// Lane rule: Address[6] == 0 selects the upper lane (UDS),
//            Address[6] == 1 selects the lower lane (LDS).
//
// Ports
//   clk         system clock, everything on the rising edge
//   rst         synchronous active-high reset
//   start       burst request, only looked at while idle
//   start_addr  first byte address (12 bits)
//   byte_count  number of bytes in the burst (0..255)
//   abort       terminates a burst in progress (error pulse, no done)
//   busy        high whenever the engine is not idle
//   done        one-cycle pulse on normal completion (also for byte_count=0)
//   error       one-cycle pulse on range fault or abort
//   Address     bus address to the memory system
//   UDS / LDS   active-low lane strobes, never low together
//   Data        byte returned by the memory system
//   out_data    captured byte
//   out_valid   out_data is valid
//   out_ready   downstream accepts out_data
//   out_last    marks the final byte of the burst (qualified by out_valid)
// -----------------------------------------------------------------------------
module rom_burst_reader #(
    parameter int          WAIT_STATES = 2,
    parameter int          ADDR_STEP   = 2,
    parameter logic [11:0] MAP_LO      = 12'h400,
    parameter logic [11:0] MAP_HI      = 12'h500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [11:0] start_addr,
    input  logic [7:0]  byte_count,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [11:0] Address,
    output logic        UDS,
    output logic        LDS,
    input  logic [7:0]  Data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last
);

    // Width of the wait-state counter; at least one bit even for zero waits.
    localparam int WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        OUTPUT = 2'd3
    } state_t;

    state_t          state_reg;
    logic [11:0]     addr_reg;
    logic [7:0]      remaining_reg;
    logic [WCW-1:0]  wait_cnt_reg;
    logic            uds_reg;
    logic            lds_reg;
    logic [7:0]      out_data_reg;
    logic            out_valid_reg;
    logic            out_last_reg;
    logic            done_reg;
    logic            error_reg;

    // -------------------------------------------------------------------------
    // Range check of the requested burst. The last address is formed 13 bits
    // wide so a burst that runs past 0xFFF shows up as >= MAP_HI instead of
    // wrapping back into the window. Only meaningful when byte_count != 0,
    // which is tested first in IDLE.
    // -------------------------------------------------------------------------
    logic [12:0] last_addr;
    logic        range_fault;

    always_comb begin
        last_addr   = {1'b0, start_addr}
                    + (13'(byte_count - 8'd1) * 13'(ADDR_STEP));
        range_fault = (start_addr < MAP_LO) || (last_addr >= {1'b0, MAP_HI});
    end

    // Handshake on the output stream.
    logic out_fire;
    assign out_fire = out_valid_reg && out_ready;

    // -------------------------------------------------------------------------
    // Main sequencer. All outputs are registers updated here.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            addr_reg      <= 12'h000;
            remaining_reg <= 8'd0;
            wait_cnt_reg  <= '0;
            uds_reg       <= 1'b1;
            lds_reg       <= 1'b1;
            out_data_reg  <= 8'h00;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            done_reg      <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            // Status outputs are single-cycle pulses.
            done_reg  <= 1'b0;
            error_reg <= 1'b0;

            if (abort && (state_reg != IDLE)) begin
                // Abort beats everything else, including a final handshake
                // landing on the same edge: strobes released, stream emptied.
                state_reg     <= IDLE;
                uds_reg       <= 1'b1;
                lds_reg       <= 1'b1;
                out_valid_reg <= 1'b0;
                out_last_reg  <= 1'b0;
                wait_cnt_reg  <= '0;
                error_reg     <= 1'b1;
            end else begin
                case (state_reg)
                    IDLE: begin
                        // abort together with start cancels the request
                        // silently.
                        if (start && !abort) begin
                            if (byte_count == 8'd0) begin
                                done_reg <= 1'b1;
                            end else if (range_fault) begin
                                error_reg <= 1'b1;
                            end else begin
                                addr_reg      <= start_addr;
                                remaining_reg <= byte_count;
                                state_reg     <= SETUP;
                            end
                        end
                    end

                    SETUP: begin
                        // Address has been stable for one cycle; open the
                        // lane matching address bit 6.
                        wait_cnt_reg <= '0;
                        uds_reg      <= addr_reg[6];
                        lds_reg      <= ~addr_reg[6];
                        state_reg    <= STROBE;
                    end

                    STROBE: begin
                        if (wait_cnt_reg == WAIT_LAST) begin
                            // Last strobe cycle: memory data is valid now.
                            out_data_reg  <= Data;
                            out_valid_reg <= 1'b1;
                            out_last_reg  <= (remaining_reg == 8'd1);
                            uds_reg       <= 1'b1;
                            lds_reg       <= 1'b1;
                            wait_cnt_reg  <= '0;
                            state_reg     <= OUTPUT;
                        end else begin
                            wait_cnt_reg <= wait_cnt_reg + 1'b1;
                        end
                    end

                    OUTPUT: begin
                        // Byte and address stay frozen until accepted.
                        if (out_fire) begin
                            out_valid_reg <= 1'b0;
                            out_last_reg  <= 1'b0;
                            remaining_reg <= remaining_reg - 8'd1;
                            if (remaining_reg > 8'd1) begin
                                addr_reg  <= addr_reg + 12'(ADDR_STEP);
                                state_reg <= SETUP;
                            end else begin
                                done_reg  <= 1'b1;
                                state_reg <= IDLE;
                            end
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign busy      = (state_reg != IDLE);
    assign done      = done_reg;
    assign error     = error_reg;
    assign Address   = addr_reg;
    assign UDS       = uds_reg;
    assign LDS       = lds_reg;
    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;

endmodule

// File: tb/tb_rom_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_rom_burst_reader
//
// Self-checking bench for rom_burst_reader. A ROM image answers on Data only
// while a strobe is low. A negedge monitor logs every strobe-low cycle, every
// accepted byte and every done/error pulse; each test task then compares the
// logs against the burst predicted from the address/lane/count rules.
// -----------------------------------------------------------------------------
module tb_rom_burst_reader;

    localparam int WS   = 2;
    localparam int STEP = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] start_addr;
    logic [7:0]  byte_count;
    logic        abort;
    logic        busy;
    logic        done;
    logic        error;
    logic [11:0] Address;
    logic        UDS;
    logic        LDS;
    logic [7:0]  Data;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    logic [7:0]  rom_mem [4096];

    int tests_run    = 0;
    int tests_failed = 0;

    rom_burst_reader #(
        .WAIT_STATES (WS),
        .ADDR_STEP   (STEP),
        .MAP_LO      (12'h400),
        .MAP_HI      (12'h500)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .byte_count (byte_count),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .Address    (Address),
        .UDS        (UDS),
        .LDS        (LDS),
        .Data       (Data),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last)
    );

    // Memory answers only while one of the strobes is asserted.
    assign Data = (!UDS || !LDS) ? rom_mem[Address] : 8'h00;

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // 0: ready low, 1: ready high, 2: random, 3: driven by the test task
    int ready_mode = 1;
    initial forever begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0: out_ready = 1'b0;
            1: out_ready = 1'b1;
            2: out_ready = 1'($urandom_range(0, 1));
            default: ;
        endcase
    end

    // ---------------------------------------------------------------- monitor
    logic [12:0] strobe_q [$];   // {lane (1 = LDS), Address} per low cycle
    logic [8:0]  byte_q   [$];   // {out_last, out_data} per handshake
    int          hs_q     [$];
    int          vrise_q  [$];
    int done_n, err_n, done_cyc, excl_err, stab_err, start_cyc, first_strobe_cyc;
    logic       prev_valid = 1'b0;
    logic       prev_hs    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial forever begin
        @(negedge clk);
        if (!UDS && !LDS) excl_err++;
        if (out_valid && (!UDS || !LDS)) excl_err++;
        if (!UDS || !LDS) begin
            if (strobe_q.size() == 0) first_strobe_cyc = cyc;
            strobe_q.push_back({!LDS, Address});
        end
        if (prev_valid && !prev_hs && (!out_valid || out_data !== prev_data)) stab_err++;
        if (out_valid && !prev_valid) vrise_q.push_back(cyc);
        if (out_valid && out_ready) begin
            byte_q.push_back({out_last, out_data});
            hs_q.push_back(cyc);
        end
        if (done) begin
            done_n++;
            done_cyc = cyc;
        end
        if (error) err_n++;
        if (start && !busy) start_cyc = cyc;
        prev_valid = out_valid;
        prev_hs    = out_valid && out_ready;
        prev_data  = out_data;
    end

    task automatic clear_logs();
        strobe_q.delete();
        byte_q.delete();
        hs_q.delete();
        vrise_q.delete();
        done_n = 0; err_n = 0; excl_err = 0; stab_err = 0;
        done_cyc = -1; start_cyc = -1; first_strobe_cyc = -1;
    endtask

    // Issue one burst and compare every log against the predicted burst.
    task automatic do_burst(input logic [11:0] a, input logic [7:0] n,
                            input bit poke, input string tag);
        int          last_a;
        bit          zero;
        bit          legal;
        int          budget;
        bit          timed_out;
        int          bad;
        logic [12:0] exp_strobe [$];
        logic [8:0]  exp_bytes  [$];
        zero   = (n == 0);
        last_a = int'(a) + (int'(n) - 1) * STEP;
        legal  = !zero && (a >= 12'h400) && (last_a < 'h500);
        if (legal) begin
            for (int i = 0; i < int'(n); i++) begin
                logic [11:0] ai;
                ai = 12'(int'(a) + i * STEP);
                for (int w = 0; w <= WS; w++) exp_strobe.push_back({ai[6], ai});
                exp_bytes.push_back({(i == int'(n) - 1), rom_mem[ai]});
            end
        end

        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; start_addr = a; byte_count = n;
        @(posedge clk); #1;
        start = 1'b0;
        if (poke && legal) begin
            // A second request while busy must be ignored.
            @(posedge clk); #1;
            start = 1'b1; start_addr = 12'h4A0; byte_count = 8'd7;
            @(posedge clk); #1;
            start = 1'b0;
        end
        budget = 0;
        while (done_n + err_n == 0 && budget < 4000) begin
            @(negedge clk); #1;
            budget++;
        end
        timed_out = (done_n + err_n == 0);
        repeat (3) @(negedge clk);
        #1;

        $display("[TB] burst %s addr=0x%03h count=%0d strobes=%0d bytes=%0d done=%0d error=%0d",
                 tag, a, n, strobe_q.size(), byte_q.size(), done_n, err_n);

        tests_run++;
        if (timed_out) begin
            tests_failed++;
            $display("FAIL %s timeout: no done/error within %0d cycles", tag, budget);
        end
        tests_run++;
        if (done_n !== ((legal || zero) ? 1 : 0) || err_n !== ((!legal && !zero) ? 1 : 0)) begin
            tests_failed++;
            $display("FAIL %s pulses: done=%0d error=%0d, required done=%0d error=%0d",
                     tag, done_n, err_n, (legal || zero) ? 1 : 0, (!legal && !zero) ? 1 : 0);
        end
        bad = 0;
        if (strobe_q.size() != exp_strobe.size()) bad = 1;
        else foreach (exp_strobe[i]) if (strobe_q[i] !== exp_strobe[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s strobe sequence: %0d strobe cycles (%0d wrong), required %0d",
                     tag, strobe_q.size(), bad, exp_strobe.size());
        end
        bad = 0;
        if (byte_q.size() != exp_bytes.size()) bad = 1;
        else foreach (exp_bytes[i]) if (byte_q[i] !== exp_bytes[i]) bad++;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL %s stream: %0d bytes (%0d wrong data/last), required %0d",
                     tag, byte_q.size(), bad, exp_bytes.size());
        end
        tests_run++;
        if (excl_err != 0 || stab_err != 0) begin
            tests_failed++;
            $display("FAIL %s protocol: strobe overlap=%0d unstable output=%0d, required 0/0",
                     tag, excl_err, stab_err);
        end
        if (legal && hs_q.size() > 0) begin
            tests_run++;
            if (done_cyc !== hs_q[hs_q.size() - 1] + 1) begin
                tests_failed++;
                $display("FAIL %s done timing: cycle %0d, required %0d",
                         tag, done_cyc, hs_q[hs_q.size() - 1] + 1);
            end
        end
        if (legal && ready_mode == 1 && vrise_q.size() > 0) begin
            tests_run++;
            if (first_strobe_cyc !== start_cyc + 2 || vrise_q[0] !== start_cyc + 2 + WS + 1) begin
                tests_failed++;
                $display("FAIL %s latency: strobe at +%0d valid at +%0d, required +2 / +%0d",
                         tag, first_strobe_cyc - start_cyc, vrise_q[0] - start_cyc, 3 + WS);
            end
            bad = 0;
            for (int i = 1; i < vrise_q.size(); i++)
                if (vrise_q[i] - vrise_q[i - 1] != WS + 3) bad++;
            tests_run++;
            if (bad != 0) begin
                tests_failed++;
                $display("FAIL %s byte spacing: %0d gaps differ, required %0d cycles each",
                         tag, bad, WS + 3);
            end
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if (Address !== 12'h000 || UDS !== 1'b1 || LDS !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset bus: Address=0x%03h UDS=%b LDS=%b, required 0x000 1 1",
                     Address, UDS, LDS);
        end
        tests_run++;
        if (out_data !== 8'h00 || out_valid !== 1'b0 || out_last !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset stream: data=0x%02h valid=%b last=%b, required 0x00 0 0",
                     out_data, out_valid, out_last);
        end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset status: busy=%b done=%b error=%b, required 0 0 0",
                     busy, done, error);
        end
    endtask

    task automatic test_single();
        ready_mode = 1;
        do_burst(12'h400, 8'd1, 1'b0, "single");
        tests_run++;
        if (byte_q.size() != 1 || byte_q[0] !== {1'b1, 8'hA5}) begin
            tests_failed++;
            $display("FAIL single byte: got %0d bytes first=0x%03h, required {last=1,0xA5}",
                     byte_q.size(), (byte_q.size() > 0) ? byte_q[0] : 9'h000);
        end
    endtask

    task automatic test_burst3();
        ready_mode = 1;
        do_burst(12'h43E, 8'd3, 1'b1, "burst3");
    endtask

    task automatic test_backpressure();
        int budget;
        int bad;
        int strobes_before;
        clear_logs();
        ready_mode = 3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b1; start_addr = 12'h400; byte_count = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        tests_run++;
        if (!out_valid) begin
            tests_failed++;
            $display("FAIL backpressure wait: out_valid never rose in %0d cycles", budget);
        end
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== rom_mem[12'h400] || UDS !== 1'b1 ||
                LDS !== 1'b1 || Address !== 12'h400) bad++;
        end
        #1;
        strobes_before = strobe_q.size();
        $display("[TB] backpressure hold: 6 cycles, %0d unstable, %0d strobe cycles",
                 bad, strobes_before);
        tests_run++;
        if (bad != 0 || strobes_before != WS + 1) begin
            tests_failed++;
            $display("FAIL backpressure hold: %0d bad cycles, %0d strobe cycles, required 0 and %0d",
                     bad, strobes_before, WS + 1);
        end
        @(posedge clk); #1;
        ready_mode = 1;
        out_ready = 1'b1;
        budget = 0;
        while (done_n + err_n == 0 && budget < 200) begin
            @(negedge clk); #1;
            budget++;
        end
        tests_run++;
        if (done_n !== 1 || byte_q.size() != 2 ||
            byte_q[0] !== {1'b0, rom_mem[12'h400]} || byte_q[1] !== {1'b1, rom_mem[12'h402]}) begin
            tests_failed++;
            $display("FAIL backpressure result: done=%0d bytes=%0d, required done=1 bytes=2 with correct data",
                     done_n, byte_q.size());
        end
    endtask

    task automatic test_bounds();
        ready_mode = 1;
        do_burst(12'h400, 8'd0,   1'b0, "count0");
        do_burst(12'h4FE, 8'd2,   1'b0, "past_end");
        do_burst(12'h3FE, 8'd1,   1'b0, "below_lo");
        do_burst(12'h4FE, 8'd1,   1'b0, "top_byte");
        do_burst(12'h400, 8'd128, 1'b0, "full_window");
    endtask

    task automatic test_abort();
        int budget;
        // Abort in the second strobe cycle of a 4-byte burst.
        ready_mode = 1;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 12'h400; byte_count = 8'd4;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (strobe_q.size() == 0 && budget < 50) begin
            @(negedge clk); #1;
            budget++;
        end
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        $display("[TB] abort mid-strobe: UDS=%b LDS=%b busy=%b error=%b valid=%b",
                 UDS, LDS, busy, error, out_valid);
        tests_run++;
        if (UDS !== 1'b1 || LDS !== 1'b1 || busy !== 1'b0 || error !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort state: UDS=%b LDS=%b busy=%b error=%b valid=%b, required 1 1 0 1 0",
                     UDS, LDS, busy, error, out_valid);
        end
        repeat (4) @(negedge clk);
        #1;
        tests_run++;
        if (strobe_q.size() != 2 || vrise_q.size() != 0 || done_n != 0 || err_n != 1) begin
            tests_failed++;
            $display("FAIL abort log: strobes=%0d valids=%0d done=%0d error=%0d, required 2 0 0 1",
                     strobe_q.size(), vrise_q.size(), done_n, err_n);
        end

        // abort and start in the same idle cycle: nothing happens.
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; start_addr = 12'h400; byte_count = 8'd1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        $display("[TB] abort+start idle: strobes=%0d done=%0d error=%0d busy=%b",
                 strobe_q.size(), done_n, err_n, busy);
        tests_run++;
        if (strobe_q.size() != 0 || done_n != 0 || err_n != 0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort+start: strobes=%0d done=%0d error=%0d busy=%b, required 0 0 0 0",
                     strobe_q.size(), done_n, err_n, busy);
        end

        // abort coincident with the final handshake.
        clear_logs();
        ready_mode = 3;
        @(posedge clk); #1;
        out_ready = 1'b0;
        start = 1'b1; start_addr = 12'h440; byte_count = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (!out_valid && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("[TB] abort on final handshake: done=%0d error=%0d", done_n, err_n);
        tests_run++;
        if (done_n != 0 || err_n != 1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort final: done=%0d error=%0d valid=%b, required 0 1 0",
                     done_n, err_n, out_valid);
        end
        ready_mode = 1;
    endtask

    task automatic test_rst_mid();
        int budget;
        ready_mode = 1;
        clear_logs();
        @(posedge clk); #1;
        start = 1'b1; start_addr = 12'h440; byte_count = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (strobe_q.size() == 0 && budget < 50) begin
            @(negedge clk); #1;
            budget++;
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        $display("[TB] reset mid-strobe: UDS=%b LDS=%b busy=%b valid=%b Address=0x%03h",
                 UDS, LDS, busy, out_valid, Address);
        tests_run++;
        if (UDS !== 1'b1 || LDS !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || Address !== 12'h000) begin
            tests_failed++;
            $display("FAIL reset mid: UDS=%b LDS=%b busy=%b valid=%b Address=0x%03h, required 1 1 0 0 0x000",
                     UDS, LDS, busy, out_valid, Address);
        end
        repeat (3) @(negedge clk);
        #1;
        tests_run++;
        if (done_n != 0 || err_n != 0) begin
            tests_failed++;
            $display("FAIL reset pulses: done=%0d error=%0d, required 0 0", done_n, err_n);
        end
        do_burst(12'h460, 8'd2, 1'b0, "after_rst");
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [11:0] a;
            logic [7:0]  n;
            a = 12'(12'h3F8 + $urandom_range(0, 12'h110));
            n = 8'($urandom_range(0, 24));
            ready_mode = (k % 3 == 0) ? 1 : 2;
            do_burst(a, n, 1'b0, "random");
        end
        ready_mode = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4096; i++) rom_mem[i] = 8'($urandom);
        rom_mem[12'h400] = 8'hA5;
        clear_logs();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = 12'h000; byte_count = 8'd0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        test_reset();
        test_single();
        test_burst3();
        test_backpressure();
        test_bounds();
        test_abort();
        test_rst_mid();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
